// File: rtl/ofs_plat_host_chan_active_line_throttle.sv
// rtl/ofs_plat_host_chan_active_line_throttle.sv - per-VC active-line admission control for host-channel requests
//
// Admits a request only while its VC's in-flight line count plus the request
// length stays within the effective limit. Returning completions retire lines.
// The block holds no requests; it only gates ready and keeps the counts.
//
// Ports:
//   clk, reset          clock and synchronous active-high reset
//   req_valid           request offered
//   req_vc              VC of the offered request
//   req_cl_len          length code: 0 = 1 line, 1 = 2, 3 = 4, 2 = illegal
//   req_ready           request may be accepted this cycle (independent of req_valid)
//   cpl_valid           completion returned
//   cpl_vc              VC of the completion
//   cpl_lines           lines retired by the completion (0 is ignored)
//   limit_override_en   select limit_override instead of MAX_ACTIVE_LINES
//   limit_override      runtime per-VC limit
//   active_lines        packed per-VC in-flight counts, VC v at [v*COUNT_W +: COUNT_W]
//   err_req             sticky: illegal length or unsupported VC offered
//   err_underflow       sticky: completion retired more lines than were in flight
//   stall_cycles        saturating count of cycles with req_valid & !req_ready

module ofs_plat_host_chan_active_line_throttle #(
    parameter int NUM_VCS = 4,
    parameter logic [NUM_VCS-1:0] VC_SUPPORTED_MASK = {NUM_VCS{1'b1}},
    parameter int MAX_ACTIVE_LINES = 64,
    parameter int COUNT_W = 8,
    parameter int STALL_CNT_W = 32,
    localparam int VC_W = (NUM_VCS > 1) ? $clog2(NUM_VCS) : 1
) (
    input  logic                         clk,
    input  logic                         reset,

    input  logic                         req_valid,
    input  logic [VC_W-1:0]              req_vc,
    input  logic [1:0]                   req_cl_len,
    output logic                         req_ready,

    input  logic                         cpl_valid,
    input  logic [VC_W-1:0]              cpl_vc,
    input  logic [2:0]                   cpl_lines,

    input  logic                         limit_override_en,
    input  logic [COUNT_W-1:0]           limit_override,

    output logic [NUM_VCS*COUNT_W-1:0]   active_lines,
    output logic                         err_req,
    output logic                         err_underflow,
    output logic [STALL_CNT_W-1:0]       stall_cycles
);

    // One extra bit so active + n never wraps before the limit compare.
    localparam int SUM_W = COUNT_W + 1;
    localparam logic [SUM_W-1:0] DEFAULT_LIMIT = SUM_W'(MAX_ACTIVE_LINES);

    logic [COUNT_W-1:0]     active_q [NUM_VCS];
    logic [COUNT_W-1:0]     active_nxt [NUM_VCS];
    logic [NUM_VCS-1:0]     vc_underflow;
    logic                   err_req_q;
    logic                   err_underflow_q;
    logic [STALL_CNT_W-1:0] stall_q;

    // ------------------------------------------------------------------
    // Request length decode
    // ------------------------------------------------------------------
    logic [2:0] req_n;
    logic       len_legal;

    always_comb begin
        req_n     = 3'd0;
        len_legal = 1'b0;
        case (req_cl_len)
            2'd0: begin req_n = 3'd1; len_legal = 1'b1; end
            2'd1: begin req_n = 3'd2; len_legal = 1'b1; end
            2'd3: begin req_n = 3'd4; len_legal = 1'b1; end
            default: begin req_n = 3'd0; len_legal = 1'b0; end
        endcase
    end

    // ------------------------------------------------------------------
    // VC lookups. Indices beyond NUM_VCS (possible when NUM_VCS is not a
    // power of two) match no entry and are therefore unsupported.
    // ------------------------------------------------------------------
    logic               req_vc_supported;
    logic [COUNT_W-1:0] req_vc_active;
    logic               cpl_vc_supported;

    always_comb begin
        req_vc_supported = 1'b0;
        req_vc_active    = '0;
        cpl_vc_supported = 1'b0;
        for (int v = 0; v < NUM_VCS; v++) begin
            if (req_vc == VC_W'(v)) begin
                req_vc_supported = VC_SUPPORTED_MASK[v];
                req_vc_active    = active_q[v];
            end
            if (cpl_vc == VC_W'(v)) begin
                cpl_vc_supported = VC_SUPPORTED_MASK[v];
            end
        end
    end

    // ------------------------------------------------------------------
    // Admission
    // ------------------------------------------------------------------
    logic [SUM_W-1:0] limit_eff;
    logic [SUM_W-1:0] req_sum;
    logic             fits;
    logic             accept;
    logic             req_bad;
    logic             cpl_unsupported;

    always_comb begin
        limit_eff = limit_override_en ? {1'b0, limit_override} : DEFAULT_LIMIT;
        req_sum   = {1'b0, req_vc_active} + SUM_W'(req_n);
        fits      = (req_sum <= limit_eff);
        req_ready = !reset && req_vc_supported && len_legal && fits;
        accept    = req_valid && req_ready;
        // A bad request never becomes ready, so it is flagged every cycle
        // it is offered until the upstream owner drops it.
        req_bad   = req_valid && (!req_vc_supported || !len_legal);
        cpl_unsupported = cpl_valid && !cpl_vc_supported && (cpl_lines != 3'd0);
    end

    // ------------------------------------------------------------------
    // Per-VC next count: accept and completion on the same VC collapse
    // into a single net update, saturating at zero on underflow.
    // ------------------------------------------------------------------
    always_comb begin : next_count
        logic [SUM_W-1:0] inc;
        logic [SUM_W-1:0] dec;
        logic [SUM_W-1:0] sum;
        inc = '0;
        dec = '0;
        sum = '0;
        vc_underflow = '0;
        for (int v = 0; v < NUM_VCS; v++) begin
            inc = (accept && (req_vc == VC_W'(v))) ? SUM_W'(req_n) : '0;
            dec = (cpl_valid && (cpl_vc == VC_W'(v)) && VC_SUPPORTED_MASK[v])
                  ? SUM_W'(cpl_lines) : '0;
            sum = {1'b0, active_q[v]} + inc;
            if (dec > sum) begin
                active_nxt[v]   = '0;
                vc_underflow[v] = 1'b1;
            end else begin
                active_nxt[v]   = COUNT_W'(sum - dec);
            end
        end
    end

    // ------------------------------------------------------------------
    // State
    // ------------------------------------------------------------------
    always_ff @(posedge clk) begin
        if (reset) begin
            for (int v = 0; v < NUM_VCS; v++) begin
                active_q[v] <= '0;
            end
            err_req_q       <= 1'b0;
            err_underflow_q <= 1'b0;
            stall_q         <= '0;
        end else begin
            for (int v = 0; v < NUM_VCS; v++) begin
                active_q[v] <= active_nxt[v];
            end
            if (req_bad) begin
                err_req_q <= 1'b1;
            end
            if ((|vc_underflow) || cpl_unsupported) begin
                err_underflow_q <= 1'b1;
            end
            if (req_valid && !req_ready && (stall_q != {STALL_CNT_W{1'b1}})) begin
                stall_q <= stall_q + STALL_CNT_W'(1);
            end
        end
    end

    // ------------------------------------------------------------------
    // Outputs
    // ------------------------------------------------------------------
    always_comb begin
        active_lines = '0;
        for (int v = 0; v < NUM_VCS; v++) begin
            active_lines[v*COUNT_W +: COUNT_W] = active_q[v];
        end
    end

    assign err_req       = err_req_q;
    assign err_underflow = err_underflow_q;
    assign stall_cycles  = stall_q;

endmodule

// File: doc/ofs_plat_host_chan_active_line_throttle.md
Name: ofs_plat_host_chan_active_line_throttle

Overview:
- Parametrised per-virtual-channel admission controller for host-channel requests.
- Tracks the number of cache lines in flight on each VC and withholds requests whose length would push that VC past its configured active-line limit.
- Successor to the static max-bandwidth active-line table: VC count, limit and counter width are parametrised, the limit is runtime-overridable, and it adds error and stall telemetry.
- One instance sits on the c0 (read) path and one on the c1 (write) path, between the AFU request arbiter and the platform edge registers.

Parameters:
- NUM_VCS, 4, number of VC indices tracked; VC index width VC_W = $clog2(NUM_VCS), minimum 1.
- VC_SUPPORTED_MASK, 4'b1111, bit v = 1 when VC v may be used; requests on other VCs are never accepted.
- MAX_ACTIVE_LINES, 64, default per-VC in-flight line limit; must be >= 4.
- COUNT_W, 8, width of per-VC counters and of the limit; 2**COUNT_W - 1 must be >= MAX_ACTIVE_LINES.
- STALL_CNT_W, 32, width of the saturating stall-cycle counter.

Ports:
- clk  input  1  clock.
- reset  input  1  synchronous active-high reset.
- req_valid  input  1  request offered.
- req_vc  input  VC_W  VC of the offered request.
- req_cl_len  input  2  line-length encoding: 0 = 1 line, 1 = 2 lines, 3 = 4 lines, 2 = illegal.
- req_ready  output  1  request may be accepted this cycle.
- cpl_valid  input  1  completion returned.
- cpl_vc  input  VC_W  VC of the completion.
- cpl_lines  input  3  lines retired by this completion, 1..4.
- limit_override_en  input  1  use limit_override instead of MAX_ACTIVE_LINES.
- limit_override  input  COUNT_W  runtime per-VC limit.
- active_lines  output  NUM_VCS*COUNT_W  per-VC in-flight count; VC v occupies bits [v*COUNT_W +: COUNT_W].
- err_req  output  1  sticky: an illegal length or unsupported VC was offered.
- err_underflow  output  1  sticky: a completion exceeded the in-flight count.
- stall_cycles  output  STALL_CNT_W  cycles with req_valid=1 and req_ready=0.

Behaviour:
- Reset: all active_lines = 0, err_req = 0, err_underflow = 0, stall_cycles = 0. req_ready = 0 in every cycle where reset = 1.
- Line count of a request: n = 1, 2 or 4 as decoded from req_cl_len.
- Effective limit: L = limit_override_en ? limit_override : MAX_ACTIVE_LINES, sampled combinationally each cycle.
  - L = 0 blocks all traffic.
  - Lowering L below a VC's current count does not drop anything; that VC simply stops accepting until it drains.
- req_ready is combinational and equals 1 only when all of the following hold:
  - reset = 0;
  - VC_SUPPORTED_MASK[req_vc] = 1;
  - req_cl_len != 2;
  - active[req_vc] + n <= L, evaluated at COUNT_W+1 bits so the sum cannot wrap.
- req_ready does not depend on req_valid. A request is accepted on a cycle with req_valid & req_ready. The counter updates on the next edge: one-cycle latency from accept to visible count.
- Completion: on cpl_valid, active[cpl_vc] is reduced by cpl_lines on the next edge.
  - cpl_lines = 0 is ignored.
  - A completion on an unsupported VC is ignored and sets err_underflow.
- Same VC, same cycle (accept and completion): next = active + n - cpl_lines, applied as one net update with no intermediate value.
- Completions are never blocked and are applied even during a stall. Different VCs update independently in the same cycle.
- Underflow: if cpl_lines > active[cpl_vc] (after adding any same-cycle accept), the counter saturates at 0 and err_underflow sets.
- err_req sets on any cycle with req_valid = 1 and either an unsupported VC or req_cl_len = 2. That request stays unaccepted indefinitely; the upstream owner must drop it.
- Both error flags stay set until reset.
- stall_cycles increments on each cycle with req_valid & !req_ready & !reset and saturates at all-ones.
- Reset mid-operation: all counters clear on that edge, and in-flight completions arriving after reset are treated as underflow.
  - Upstream must also reset, so this case is not expected in normal operation.
- The block has no storage of requests; it is pure admission control plus state.

Test Plan:
- Reset, then 16 accepts of req_cl_len=3 on VC0 with MAX_ACTIVE_LINES=64 -> active_lines[VC0] = 64 one cycle after the last accept. A 17th offer sees req_ready = 0 and stall_cycles counts each cycle it waits.
- From 64 on VC0, cpl_valid with cpl_lines=4 on VC0 -> active = 60 next cycle. A pending 4-line request is accepted that same next cycle, then active = 64.
- Same-cycle accept of 2 lines and completion of 1 line on VC1 with active = 10 -> active = 11. Accept on VC2 plus completion on VC3 in the same cycle -> both update independently.
- VC_SUPPORTED_MASK = 4'b0011: offer on VC2, then offer with req_cl_len = 2 on VC0 -> req_ready = 0 for both, err_req = 1 and held. Other VCs continue normally.
- active[VC0] = 1, completion with cpl_lines = 4 -> active = 0 and err_underflow = 1.
- limit_override_en = 1, limit_override = 8 while active[VC0] = 20 -> no accepts on VC0 until it drains to 7 or below for a 1-line request. Setting limit_override = 0 -> req_ready = 0 on all VCs.
